// File: rtl/control_actualizacion_filas_n_pkg.sv
// control_filas_pkg
// Shared definitions for the row-update controller: FSM state encoding,
// a constant-evaluable clog2 and the derived port widths for the default
// parameterisation (3-row window, 480-row image).
package control_filas_pkg;

  localparam logic [1:0] ST_INICIO     = 2'd0;
  localparam logic [1:0] ST_PULSO      = 2'd1;
  localparam logic [1:0] ST_ESPERA     = 2'd2;
  localparam logic [1:0] ST_FIN_IMAGEN = 2'd3;

  typedef enum logic [1:0] {
    E_INICIO     = ST_INICIO,
    E_PULSO      = ST_PULSO,
    E_ESPERA     = ST_ESPERA,
    E_FIN_IMAGEN = ST_FIN_IMAGEN
  } estado_t;

  function automatic int clog2(input int valor);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < valor) res = i + 1;
    end
    return res;
  endfunction

  // A 1-row window still needs a 1-bit slot index to keep ports legal.
  function automatic int ancho_idx(input int num_filas);
    return (clog2(num_filas) < 1) ? 1 : clog2(num_filas);
  endfunction

  // Row counter must be able to hold ALTO_IMAGEN itself (frame complete).
  function automatic int ancho_img(input int alto_imagen);
    return clog2(alto_imagen + 1);
  endfunction

  localparam int NUM_FILAS_DEF   = 3;
  localparam int ALTO_IMAGEN_DEF = 480;
  localparam int ANCHO_IDX       = ancho_idx(NUM_FILAS_DEF);
  localparam int ANCHO_IMG       = ancho_img(ALTO_IMAGEN_DEF);

endpackage

// File: rtl/control_actualizacion_filas_n_if.sv
// control_actualizacion_filas_n_if
// Bundle between the window sequencer (master) and the row-update
// controller (slave).
//   requests (master -> slave): actualizar_primera_ventana, actualizar_ventana,
//                               fila_lista, nuevo_cuadro
//   status   (slave -> master): iniciar_actualizacion, contar_fila, ocupado,
//                               filas_actualizadas, fin_imagen,
//                               indice_fila[ANCHO_IDX], fila_imagen[ANCHO_IMG]
interface control_actualizacion_filas_n_if #(
  parameter int ANCHO_IDX = control_filas_pkg::ANCHO_IDX,
  parameter int ANCHO_IMG = control_filas_pkg::ANCHO_IMG
);

  logic                 actualizar_primera_ventana;
  logic                 actualizar_ventana;
  logic                 fila_lista;
  logic                 nuevo_cuadro;

  logic                 iniciar_actualizacion;
  logic                 contar_fila;
  logic                 ocupado;
  logic                 filas_actualizadas;
  logic                 fin_imagen;
  logic [ANCHO_IDX-1:0] indice_fila;
  logic [ANCHO_IMG-1:0] fila_imagen;

  modport master (
    output actualizar_primera_ventana, actualizar_ventana, fila_lista, nuevo_cuadro,
    input  iniciar_actualizacion, contar_fila, ocupado, filas_actualizadas,
           fin_imagen, indice_fila, fila_imagen
  );

  modport slave (
    input  actualizar_primera_ventana, actualizar_ventana, fila_lista, nuevo_cuadro,
    output iniciar_actualizacion, contar_fila, ocupado, filas_actualizadas,
           fin_imagen, indice_fila, fila_imagen
  );

endinterface

// File: rtl/control_actualizacion_filas_n_contador.sv
// contador_modulo_n
// Modulo-MODULO up-counter with synchronous clear; drives the rotating
// window slot index.
//   clk, reset   : clock, synchronous active-high reset
//   limpiar      : clear to 0 (wins over habilitar)
//   habilitar    : advance by one, wrapping MODULO-1 -> 0
//   cuenta       : current count
module contador_modulo_n
  import control_filas_pkg::*;
#(
  parameter int MODULO = 3,
  parameter int ANCHO  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             limpiar,
  input  logic             habilitar,
  output logic [ANCHO-1:0] cuenta
);

  localparam logic [ANCHO-1:0] MAXIMO = ANCHO'(MODULO - 1);
  localparam logic [ANCHO-1:0] UNO    = ANCHO'(1);

  logic [ANCHO-1:0] cuenta_q;
  logic [ANCHO-1:0] cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (limpiar) begin
      cuenta_d = '0;
    end else if (habilitar) begin
      cuenta_d = (cuenta_q == MAXIMO) ? '0 : cuenta_q + UNO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cuenta_q <= '0;
    else       cuenta_q <= cuenta_d;
  end

  assign cuenta = cuenta_q;

endmodule

// File: rtl/control_actualizacion_filas_n.sv
// control_actualizacion_filas_n
// Row-update controller for the sliding-window filter: preloads NUM_FILAS
// rows for the first window of a frame, then one row per window advance,
// handshaking each row with the line buffer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of control_actualizacion_filas_n_if
//                (requests/ack/abort in, pulse, slot, row count, flags out)
//
//   state        | meaning
//   E_INICIO     | idle, accepting preload/advance requests
//   E_PULSO      | one-cycle start pulse for the current row
//   E_ESPERA     | waiting for fila_lista from the line buffer
//   E_FIN_IMAGEN | whole frame loaded; only nuevo_cuadro/reset leave
module control_actualizacion_filas_n
  import control_filas_pkg::*;
#(
  parameter int NUM_FILAS   = 3,
  parameter int ALTO_IMAGEN = 480
) (
  input  logic                            clk,
  input  logic                            reset,
  control_actualizacion_filas_n_if.slave  bus
);

  localparam int W_IDX = ancho_idx(NUM_FILAS);
  localparam int W_IMG = ancho_img(ALTO_IMAGEN);
  localparam int W_RES = W_IDX + 1;

  localparam logic [W_RES-1:0] RES_PRIMERA = W_RES'(NUM_FILAS);
  localparam logic [W_RES-1:0] RES_UNA     = W_RES'(1);
  localparam logic [W_IMG-1:0] FILA_ULTIMA = W_IMG'(ALTO_IMAGEN);
  localparam logic [W_IMG-1:0] FILA_UNO    = W_IMG'(1);

  estado_t           estado_q, estado_d;
  logic [W_RES-1:0]  restantes_q, restantes_d;
  logic [W_IMG-1:0]  fila_imagen_q, fila_imagen_d;
  logic              filas_act_q, filas_act_d;

  logic              idx_limpiar;
  logic              idx_habilitar;
  logic [W_IDX-1:0]  indice;
  logic [W_IMG-1:0]  fila_siguiente;

  assign fila_siguiente = fila_imagen_q + FILA_UNO;

  always_comb begin
    estado_d      = estado_q;
    restantes_d   = restantes_q;
    fila_imagen_d = fila_imagen_q;
    filas_act_d   = filas_act_q;
    idx_limpiar   = 1'b0;
    idx_habilitar = 1'b0;

    if (bus.nuevo_cuadro) begin
      // Abort beats any ack arriving in the same cycle.
      estado_d      = E_INICIO;
      restantes_d   = '0;
      fila_imagen_d = '0;
      filas_act_d   = 1'b0;
      idx_limpiar   = 1'b1;
    end else begin
      unique case (estado_q)
        E_INICIO: begin
          // The two requests are mutually exclusive on filas_act_q, so at
          // most one can be taken.
          if (bus.actualizar_primera_ventana && !filas_act_q) begin
            restantes_d = RES_PRIMERA;
            estado_d    = E_PULSO;
          end else if (bus.actualizar_ventana && filas_act_q) begin
            restantes_d = RES_UNA;
            estado_d    = E_PULSO;
          end
        end

        E_PULSO: begin
          estado_d = E_ESPERA;
        end

        E_ESPERA: begin
          if (bus.fila_lista) begin
            fila_imagen_d = fila_siguiente;
            idx_habilitar = 1'b1;
            restantes_d   = restantes_q - RES_UNA;
            if (fila_siguiente == FILA_ULTIMA) begin
              // A completed frame always holds a full window.
              estado_d    = E_FIN_IMAGEN;
              filas_act_d = 1'b1;
            end else if (restantes_q == RES_UNA) begin
              estado_d    = E_INICIO;
              filas_act_d = 1'b1;
            end else begin
              estado_d    = E_PULSO;
            end
          end
        end

        E_FIN_IMAGEN: begin
          estado_d = E_FIN_IMAGEN;
        end

        default: begin
          estado_d = E_INICIO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q      <= E_INICIO;
      restantes_q   <= '0;
      fila_imagen_q <= '0;
      filas_act_q   <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      restantes_q   <= restantes_d;
      fila_imagen_q <= fila_imagen_d;
      filas_act_q   <= filas_act_d;
    end
  end

  contador_modulo_n #(
    .MODULO (NUM_FILAS),
    .ANCHO  (W_IDX)
  ) u_indice_fila (
    .clk       (clk),
    .reset     (reset),
    .limpiar   (idx_limpiar),
    .habilitar (idx_habilitar),
    .cuenta    (indice)
  );

  assign bus.iniciar_actualizacion = (estado_q == E_PULSO);
  assign bus.contar_fila           = (estado_q == E_PULSO);
  assign bus.ocupado               = (estado_q == E_PULSO) || (estado_q == E_ESPERA);
  assign bus.filas_actualizadas    = filas_act_q;
  assign bus.fin_imagen            = (estado_q == E_FIN_IMAGEN);
  assign bus.indice_fila           = indice;
  assign bus.fila_imagen           = fila_imagen_q;

endmodule

// File: tb/tb_control_actualizacion_filas_n.sv
module tb_control_actualizacion_filas_n;
  import control_filas_pkg::*;

  localparam int NF   = 3;
  localparam int AI   = 5;
  localparam int IDXW = ancho_idx(NF);
  localparam int IMGW = ancho_img(AI);
  localparam int VW   = 5 + IDXW + IMGW;

  logic clk;
  logic reset;

  control_actualizacion_filas_n_if #(.ANCHO_IDX(IDXW), .ANCHO_IMG(IMGW)) bus ();

  control_actualizacion_filas_n #(.NUM_FILAS(NF), .ALTO_IMAGEN(AI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  // Reference model: rows still owed in the current burst, whether a start
  // pulse is due this cycle, rows loaded, window-full and frame-done flags.
  int m_pend  = 0;
  int m_rows  = 0;
  bit m_pulse = 0;
  bit m_win   = 0;
  bit m_end   = 0;

  task automatic model_step(input bit f, input bit a, input bit l, input bit n, input bit r);
    if (r || n) begin
      m_pend = 0; m_rows = 0; m_pulse = 0; m_win = 0; m_end = 0;
    end else if (m_end) begin
      m_pend = 0;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (m_pend > 0) begin
      if (l) begin
        m_rows++;
        m_pend--;
        if (m_rows == AI) begin
          m_end = 1; m_win = 1; m_pend = 0;
        end else if (m_pend == 0) begin
          m_win = 1;
        end else begin
          m_pulse = 1;
        end
      end
    end else if (f && !m_win) begin
      m_pend = NF; m_pulse = 1;
    end else if (a && m_win) begin
      m_pend = 1; m_pulse = 1;
    end
  endtask

  function automatic logic [VW-1:0] obs();
    return {bus.iniciar_actualizacion, bus.contar_fila, bus.ocupado,
            bus.filas_actualizadas, bus.fin_imagen, bus.indice_fila, bus.fila_imagen};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_pulse, m_pulse, (m_pend > 0), m_win, m_end,
            IDXW'(m_rows % NF), IMGW'(m_rows)};
  endfunction

  // Drive inputs at the falling edge, let one rising edge pass, step the
  // model with the same inputs, then return at the next falling edge.
  task automatic tick(input bit f, input bit a, input bit l, input bit n, input bit r);
    bus.actualizar_primera_ventana = f;
    bus.actualizar_ventana         = a;
    bus.fila_lista                 = l;
    bus.nuevo_cuadro               = n;
    reset                          = r;
    @(posedge clk);
    model_step(f, a, l, n, r);
    @(negedge clk);
    if (bus.iniciar_actualizacion === 1'b1) pulse_cnt++;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle: got %h expected %h", obs(), exp_vec());
    end
  endtask

  task automatic test_first_window();
    int d[3] = '{2, 0, 5};
    int p0;
    p0 = pulse_cnt;
    tick(1, 0, 0, 0, 0);
    for (int r = 0; r < NF; r++) begin
      checks++;
      if (bus.iniciar_actualizacion !== 1'b1 || bus.indice_fila !== IDXW'(r)) begin
        errors++; $display("FAIL fw_pulse row %0d: pulse %b idx %0d expected pulse 1 idx %0d",
                           r, bus.iniciar_actualizacion, bus.indice_fila, r);
      end
      tick(0, 0, 0, 0, 0);
      repeat (d[r]) tick(0, 0, 0, 0, 0);
      checks++;
      if (bus.filas_actualizadas !== 1'b0) begin
        errors++; $display("FAIL fw_early_flag row %0d: got %b expected 0", r, bus.filas_actualizadas);
      end
      tick(0, 0, 1, 0, 0);
      checks++;
      if (bus.fila_imagen !== IMGW'(r + 1) || bus.indice_fila !== IDXW'((r + 1) % NF)) begin
        errors++; $display("FAIL fw_counters row %0d: fila %0d idx %0d expected fila %0d idx %0d",
                           r, bus.fila_imagen, bus.indice_fila, r + 1, (r + 1) % NF);
      end
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL fw_model row %0d: got %h expected %h", r, obs(), exp_vec());
      end
    end
    checks++;
    if (bus.filas_actualizadas !== 1'b1 || bus.ocupado !== 1'b0) begin
      errors++; $display("FAIL fw_flag: filas %b ocupado %b expected 1 0",
                         bus.filas_actualizadas, bus.ocupado);
    end
    checks++;
    if (pulse_cnt - p0 != NF) begin
      errors++; $display("FAIL fw_pulse_count: got %0d expected %0d", pulse_cnt - p0, NF);
    end
  endtask

  task automatic test_advance();
    int p0;
    p0 = pulse_cnt;
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    checks++;
    if (pulse_cnt != p0) begin
      errors++; $display("FAIL adv_first_ignored: got %0d pulses expected 0", pulse_cnt - p0);
    end
    tick(0, 1, 0, 0, 0);
    checks++;
    if (bus.iniciar_actualizacion !== 1'b1) begin
      errors++; $display("FAIL adv_pulse: got %b expected 1", bus.iniciar_actualizacion);
    end
    tick(0, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    checks++;
    if (bus.fila_imagen !== IMGW'(4) || bus.ocupado !== 1'b0 || bus.filas_actualizadas !== 1'b1) begin
      errors++; $display("FAIL adv_done: fila %0d ocupado %b filas %b expected 4 0 1",
                         bus.fila_imagen, bus.ocupado, bus.filas_actualizadas);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    checks++;
    if (pulse_cnt - p0 != 1) begin
      errors++; $display("FAIL adv_pulse_count: got %0d expected 1", pulse_cnt - p0);
    end
    checks++;
    if (obs() !== exp_vec()) begin
      errors++; $display("FAIL adv_model: got %h expected %h", obs(), exp_vec());
    end
  endtask

  task automatic test_end_of_frame();
    int p0;
    tick(1, 1, 0, 0, 0);
    checks++;
    if (bus.iniciar_actualizacion !== 1'b1) begin
      errors++; $display("FAIL eof_pulse: got %b expected 1", bus.iniciar_actualizacion);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    checks++;
    if (bus.fin_imagen !== 1'b1 || bus.fila_imagen !== IMGW'(AI) ||
        bus.filas_actualizadas !== 1'b1 || bus.ocupado !== 1'b0) begin
      errors++; $display("FAIL eof_state: fin %b fila %0d filas %b ocupado %b expected 1 %0d 1 0",
                         bus.fin_imagen, bus.fila_imagen, bus.filas_actualizadas, bus.ocupado, AI);
    end
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) tick(bit'(i % 2), 1, 1, 0, 0);
    checks++;
    if (pulse_cnt != p0 || bus.fin_imagen !== 1'b1 || bus.fila_imagen !== IMGW'(AI)) begin
      errors++; $display("FAIL eof_hold: pulses %0d fin %b fila %0d expected 0 1 %0d",
                         pulse_cnt - p0, bus.fin_imagen, bus.fila_imagen, AI);
    end
    checks++;
    if (obs() !== exp_vec()) begin
      errors++; $display("FAIL eof_model: got %h expected %h", obs(), exp_vec());
    end
  endtask

  task automatic test_nuevo_cuadro();
    int cnt;
    tick(0, 0, 0, 1, 0);
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL nc_from_fin: got %h expected 0", obs());
    end
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 1, 0);
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL nc_with_ack: got %h expected 0", obs());
    end
    checks++;
    if (obs() !== exp_vec()) begin
      errors++; $display("FAIL nc_model: got %h expected %h", obs(), exp_vec());
    end
    tick(1, 0, 0, 0, 0);
    checks++;
    if (bus.iniciar_actualizacion !== 1'b1 || bus.indice_fila !== '0) begin
      errors++; $display("FAIL nc_restart: pulse %b idx %0d expected 1 0",
                         bus.iniciar_actualizacion, bus.indice_fila);
    end
    cnt = 0;
    while (bus.filas_actualizadas !== 1'b1 && cnt < 20) begin
      tick(0, 0, bus.ocupado && !bus.iniciar_actualizacion, 0, 0);
      cnt++;
    end
    checks++;
    if (cnt != 2 * NF) begin
      errors++; $display("FAIL nc_preload_latency: got %0d cycles expected %0d", cnt, 2 * NF);
    end
  endtask

  task automatic test_stray_ack();
    tick(0, 0, 1, 0, 0);
    checks++;
    if (bus.fila_imagen !== IMGW'(NF) || bus.indice_fila !== '0 || bus.ocupado !== 1'b0) begin
      errors++; $display("FAIL stray_idle: fila %0d idx %0d ocupado %b expected %0d 0 0",
                         bus.fila_imagen, bus.indice_fila, bus.ocupado, NF);
    end
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    checks++;
    if (bus.fila_imagen !== IMGW'(NF) || bus.ocupado !== 1'b1 || bus.iniciar_actualizacion !== 1'b0) begin
      errors++; $display("FAIL stray_pulse: fila %0d ocupado %b pulse %b expected %0d 1 0",
                         bus.fila_imagen, bus.ocupado, bus.iniciar_actualizacion, NF);
    end
    tick(0, 0, 1, 0, 0);
    checks++;
    if (bus.fila_imagen !== IMGW'(NF + 1) || bus.indice_fila !== IDXW'(1)) begin
      errors++; $display("FAIL stray_recover: fila %0d idx %0d expected %0d 1",
                         bus.fila_imagen, bus.indice_fila, NF + 1);
    end
  endtask

  task automatic test_reset_mid_burst();
    int p0;
    tick(0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    checks++;
    if (bus.iniciar_actualizacion !== 1'b1 || bus.fila_imagen !== IMGW'(1)) begin
      errors++; $display("FAIL rst_setup: pulse %b fila %0d expected 1 1",
                         bus.iniciar_actualizacion, bus.fila_imagen);
    end
    tick(0, 0, 0, 0, 1);
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL rst_mid_burst: got %h expected 0", obs());
    end
    p0 = pulse_cnt;
    repeat (5) tick(0, 0, 1, 0, 0);
    checks++;
    if (pulse_cnt != p0 || obs() !== '0) begin
      errors++; $display("FAIL rst_quiet: pulses %0d out %h expected 0 0", pulse_cnt - p0, obs());
    end
  endtask

  task automatic test_random();
    bit f, a, l, n, r;
    for (int i = 0; i < 3000; i++) begin
      f = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 4) == 0);
      l = ($urandom_range(0, 1) == 0);
      n = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 199) == 0);
      tick(f, a, l, n, r);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.actualizar_primera_ventana = 1'b0;
    bus.actualizar_ventana         = 1'b0;
    bus.fila_lista                 = 1'b0;
    bus.nuevo_cuadro               = 1'b0;
    reset                          = 1'b1;
    test_reset();
    test_first_window();
    test_advance();
    test_end_of_frame();
    test_nuevo_cuadro();
    test_stray_ack();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
